// File: rtl/fs_serial_sub_if.sv
`default_nettype none
// ============================================================================
// Module   : fs_serial_sub_if
// Brief    : Start/done handshake and operand/result bundle for fs_serial_sub.
// Revision : 1.0 - initial release
// ============================================================================
interface fs_serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
endinterface
`default_nettype wire

// File: rtl/fs_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : fs_serial_sub
// Brief    : Bit-serial subtractor, diff = a - b, one bit per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module fs_serial_sub #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fs_serial_sub_if.slave bus
);

    localparam int            c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_x, w_x_nxt;
    logic [WIDTH-1:0]   r_y, w_y_nxt;
    logic [WIDTH-1:0]   r_diff, w_diff_nxt;
    logic               r_bin, w_bin_nxt;
    logic               r_msb_a, w_msb_a_nxt;
    logic               r_msb_b, w_msb_b_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_borrow, w_borrow_nxt;
    logic               r_ovf, w_ovf_nxt;

    logic               w_d;
    logic               w_bout;

    // Full-subtractor cell on the current operand LSBs: {bout, d}
    assign w_d    = r_x[0] ^ r_y[0] ^ r_bin;
    assign w_bout = (~r_x[0] & r_y[0]) | (~(r_x[0] ^ r_y[0]) & r_bin);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_diff_nxt   = r_diff;
        w_bin_nxt    = r_bin;
        w_msb_a_nxt  = r_msb_a;
        w_msb_b_nxt  = r_msb_b;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_borrow_nxt = r_borrow;
        w_ovf_nxt    = r_ovf;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                    w_x_nxt     = bus.a;
                    w_y_nxt     = bus.b;
                    w_bin_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_msb_a_nxt = bus.a[WIDTH-1];
                    w_msb_b_nxt = bus.b[WIDTH-1];
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                w_diff_nxt = {w_d, r_diff[WIDTH-1:1]};
                w_bin_nxt  = w_bout;
                w_x_nxt    = r_x >> 1;
                w_y_nxt    = r_y >> 1;
                w_cnt_nxt  = r_cnt + c_CW'(1);
                if (r_cnt == c_LAST) begin
                    // Last bit: w_d is the result MSB, so finalise flags now
                    w_state_nxt  = S_DONE;
                    w_busy_nxt   = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_borrow_nxt = w_bout;
                    w_ovf_nxt    = (r_msb_a != r_msb_b) && (w_d != r_msb_a);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_diff   <= '0;
            r_bin    <= 1'b0;
            r_msb_a  <= 1'b0;
            r_msb_b  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_diff   <= w_diff_nxt;
            r_bin    <= w_bin_nxt;
            r_msb_a  <= w_msb_a_nxt;
            r_msb_b  <= w_msb_b_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_borrow <= w_borrow_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
    assign bus.ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fs_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_fs_serial_sub
// Brief    : Directed and randomised checks of fs_serial_sub at WIDTH 8 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fs_serial_sub;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fs_serial_sub_if #(.WIDTH(8))  if8 ();
    fs_serial_sub_if #(.WIDTH(16)) if16 ();

    fs_serial_sub #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    fs_serial_sub #(.WIDTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one 8-bit operation; lat = edges from the accept edge to done (-1 on timeout)
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] od, output logic ob, output logic oo,
                        output int lat, output bit busy_ok);
        bit found;
        if8.a = ia;
        if8.b = ib;
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        found = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (!found) begin
                if (if8.done) begin
                    found = 1'b1;
                    lat = i;
                    if (if8.busy) busy_ok = 1'b0;
                end else begin
                    if (!if8.busy) busy_ok = 1'b0;
                    step();
                end
            end
        end
        od = if8.diff;
        ob = if8.borrow;
        oo = if8.ovf;
    endtask

    task automatic run16(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] od, output logic ob, output logic oo,
                         output int lat);
        bit found;
        if16.a = ia;
        if16.b = ib;
        if16.start = 1'b1;
        step();
        if16.start = 1'b0;
        lat = -1;
        found = 1'b0;
        for (int i = 0; i <= 60; i++) begin
            if (!found) begin
                if (if16.done) begin
                    found = 1'b1;
                    lat = i;
                end else begin
                    step();
                end
            end
        end
        od = if16.diff;
        ob = if16.borrow;
        oo = if16.ovf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({if8.busy, if8.done, if8.diff, if8.borrow, if8.ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b diff=%h borrow=%b ovf=%b, expected all 0",
                     if8.busy, if8.done, if8.diff, if8.borrow, if8.ovf);
        end
        checks++;
        if ({if16.busy, if16.done, if16.diff, if16.borrow, if16.ovf} !== 20'h00000) begin
            errors++;
            $display("FAIL reset16: busy=%b done=%b diff=%h borrow=%b ovf=%b, expected all 0",
                     if16.busy, if16.done, if16.diff, if16.borrow, if16.ovf);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic bo, ov;
        int lat;
        bit bok;
        run8(8'd5, 8'd3, d, bo, ov, lat, bok);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges after accept, expected 8", lat);
        end
        checks++;
        if (bok !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy profile wrong, got ok=%b expected 1", bok);
        end
        checks++;
        if ({d, bo, ov} !== {8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got diff=%h borrow=%b ovf=%b, expected 02 0 0", d, bo, ov);
        end
        step();
        checks++;
        if (if8.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, expected 0", if8.done);
        end
    endtask

    task automatic test_negative();
        logic [7:0] d;
        logic bo, ov;
        int lat;
        bit bok;
        run8(8'd3, 8'd5, d, bo, ov, lat, bok);
        checks++;
        if ({d, bo, ov} !== {8'hFE, 1'b1, 1'b0} || lat !== 8) begin
            errors++;
            $display("FAIL neg_result: got diff=%h borrow=%b ovf=%b lat=%0d, expected FE 1 0 lat 8",
                     d, bo, ov, lat);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({if8.diff, if8.borrow, if8.ovf, if8.done} !== {8'hFE, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL neg_hold%0d: got diff=%h borrow=%b ovf=%b done=%b, expected FE 1 0 0",
                         i, if8.diff, if8.borrow, if8.ovf, if8.done);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic bo, ov;
        int lat;
        bit bok;
        run8(8'h80, 8'h01, d, bo, ov, lat, bok);
        checks++;
        if ({d, bo, ov} !== {8'h7F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_pos: got diff=%h borrow=%b ovf=%b, expected 7F 0 1", d, bo, ov);
        end
        run8(8'h7F, 8'hFF, d, bo, ov, lat, bok);
        checks++;
        if ({d, bo, ov} !== {8'h80, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_neg: got diff=%h borrow=%b ovf=%b, expected 80 1 1", d, bo, ov);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] d;
        logic bo, ov;
        int lat;
        bit bok;
        run8(8'h3C, 8'h3C, d, bo, ov, lat, bok);
        checks++;
        if ({d, bo, ov} !== {8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL equal: got diff=%h borrow=%b ovf=%b, expected 00 0 0", d, bo, ov);
        end
        run8(8'hA5, 8'h00, d, bo, ov, lat, bok);
        checks++;
        if ({d, bo, ov} !== {8'hA5, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b_zero: got diff=%h borrow=%b ovf=%b, expected A5 0 0", d, bo, ov);
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        bit found;
        if8.a = 8'h10;
        if8.b = 8'h01;
        if8.start = 1'b1;
        step();
        if8.a = 8'h20;
        n1 = -1;
        found = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            if (!found) begin
                if (if8.done) begin
                    found = 1'b1;
                    n1 = i;
                end else begin
                    step();
                end
            end
        end
        checks++;
        if (if8.diff !== 8'h0F || n1 !== 8) begin
            errors++;
            $display("FAIL b2b_first: got diff=%h lat=%0d, expected 0F lat 8", if8.diff, n1);
        end
        step();
        if8.start = 1'b0;
        checks++;
        if (if8.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b after start in done cycle, expected 1", if8.busy);
        end
        n2 = -1;
        found = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!found) begin
                if (if8.done) begin
                    found = 1'b1;
                    n2 = i;
                end else begin
                    step();
                end
            end
        end
        checks++;
        if (if8.diff !== 8'h1F || n2 !== 9) begin
            errors++;
            $display("FAIL b2b_second: got diff=%h after %0d cycles, expected 1F after 9", if8.diff, n2);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        logic bo, ov;
        int lat;
        bit bok;
        int seen_done;
        if8.a = 8'hAA;
        if8.b = 8'h55;
        if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({if8.busy, if8.done, if8.diff, if8.borrow, if8.ovf} !== 12'h000) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b diff=%h borrow=%b ovf=%b, expected all 0",
                     if8.busy, if8.done, if8.diff, if8.borrow, if8.ovf);
        end
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if8.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL midrun_nodone: got %0d done pulses, expected 0", seen_done);
        end
        if8.start = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if8.start = 1'b0;
        checks++;
        if (if8.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_vs_start: busy=%b, expected 0", if8.busy);
        end
        step();
        run8(8'hAA, 8'h55, d, bo, ov, lat, bok);
        checks++;
        if ({d, bo, ov} !== {8'h55, 1'b0, 1'b1} || lat !== 8) begin
            errors++;
            $display("FAIL midrun_rerun: got diff=%h borrow=%b ovf=%b lat=%0d, expected 55 0 1 lat 8",
                     d, bo, ov, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0]  a8, b8, d8, ed8;
        logic [15:0] a16, b16, d16, ed16;
        logic bo, ov, eb, eo;
        int lat;
        bit bok;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            {eb, ed8} = {1'b0, a8} - {1'b0, b8};
            eo = (a8[7] != b8[7]) && (ed8[7] != a8[7]);
            run8(a8, b8, d8, bo, ov, lat, bok);
            checks++;
            if ({d8, bo, ov} !== {ed8, eb, eo} || lat !== 8) begin
                errors++;
                $display("FAIL rand8 %h-%h: got diff=%h borrow=%b ovf=%b lat=%0d, expected %h %b %b lat 8",
                         a8, b8, d8, bo, ov, lat, ed8, eb, eo);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            {eb, ed16} = {1'b0, a16} - {1'b0, b16};
            eo = (a16[15] != b16[15]) && (ed16[15] != a16[15]);
            run16(a16, b16, d16, bo, ov, lat);
            checks++;
            if ({d16, bo, ov} !== {ed16, eb, eo} || lat !== 16) begin
                errors++;
                $display("FAIL rand16 %h-%h: got diff=%h borrow=%b ovf=%b lat=%0d, expected %h %b %b lat 16",
                         a16, b16, d16, bo, ov, lat, ed16, eb, eo);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if8.start = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if16.start = 1'b0;
        if16.a = '0;
        if16.b = '0;
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fs_serial_sub.md
Name: fs_serial_sub

Overview:
- Bit-serial unsigned/two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first.
- The per-bit cell is a full-subtractor function returning {borrow_out, diff_bit}. This is the inverse arithmetic of the full-adder function used elsewhere in the arithmetic library.
- Used where area matters more than latency. A start/done handshake lets a controller launch an operation and collect the result.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the block is not busy.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- busy  output  1  high while the subtraction is in progress.
- done  output  1  one-cycle pulse when diff/borrow/ovf become valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff a < b as unsigned values.
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB].

Behaviour:
- States: IDLE, RUN, DONE. All state and outputs are registered.
- Reset (rst=1 at a rising edge; takes priority over everything):
  - state goes to IDLE; bit counter goes to 0.
  - busy=0, done=0, diff=0, borrow=0, ovf=0.
  - Internal operand shift registers and the borrow flip-flop are cleared.
- Start acceptance:
  - start is accepted in IDLE and in DONE. It is ignored in RUN; operands are not re-captured and the result is unaffected.
- Accepted start:
  - Capture a and b into shift registers, clear the borrow flip-flop, set counter=0.
  - Latch the MSBs of a and b for the ovf computation.
  - Next state RUN; busy=1 from the next cycle.
  - done is deasserted.
- RUN, each cycle:
  - Per-bit cell: d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
  - x and y are the current LSBs of the operand shift registers; bin is the borrow flip-flop.
  - d is shifted into the diff register MSB-first (right shift), so after WIDTH cycles bit 0 of diff is the first computed bit.
  - The borrow flip-flop takes bout; the operand registers shift right by 1; the counter increments.
  - When counter == WIDTH-1, the next state is DONE.
- Outputs during RUN:
  - diff, borrow and ovf are not guaranteed valid; the bench must not check them.
  - The diff register is updated in place.
- DONE (exactly one cycle unless a new start is accepted):
  - done=1, busy=0.
  - borrow = final borrow flip-flop; ovf computed from the latched MSBs and diff[MSB].
  - Next state IDLE, or RUN if start=1 (back-to-back operation).
- Results hold: diff, borrow and ovf stay stable after DONE until the next accepted start.
- Latency:
  - start accepted at edge k; RUN occupies edges k+1 .. k+WIDTH.
  - done is high during the cycle after edge k+WIDTH.
  - Total of WIDTH+1 cycles from the start edge to the done cycle.
  - Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- Boundary conditions:
  - Counter width is clog2(WIDTH)+1 with no wrap.
  - a == b gives diff=0, borrow=0, ovf=0.
  - b = 0 gives diff = a, borrow=0.
  - rst asserted mid-RUN aborts the operation immediately: the IDLE/zero state on the next edge, and no done pulse is produced.
  - start and rst high together: rst wins.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8, a=5, b=3, single start pulse -> done exactly 9 cycles after the start edge; diff=0x02, borrow=0, ovf=0; busy high for cycles 1..8.
- a=3, b=5 -> diff=0xFE, borrow=1, ovf=0; diff/borrow held stable for 5 idle cycles after done.
- a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, ovf=1.
- start held high continuously, a=0x10 then a=0x20 presented during RUN, b=0x01:
  - first result is 0x0F (mid-run operands ignored);
  - start in the DONE cycle is accepted; the second result of 0x1F arrives 9 cycles later.
- rst pulsed at the 4th RUN cycle of a=0xAA, b=0x55 -> no done pulse; all outputs 0 the next cycle; a following start with a=0xAA, b=0x55 gives diff=0x55, borrow=0.
- Randomized sweep, 1000 pairs, WIDTH=8 and WIDTH=16 -> diff, borrow and ovf match the reference model {borrow, diff} = {1'b0, a} - {1'b0, b} and the signed-overflow rule.
